fifo_burst_reader: RTL and testbench

//  Single-clock read-side consumer of the dual-clock LUT FIFO. Watches FIFO level/empty, drains fixed-size

---
 rtl/fifo_burst_reader_if.sv | 31 +++
 rtl/fifo_burst_reader.sv | 111 +++++++++++
 tb/tb_fifo_burst_reader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Read port of the upstream LUT FIFO plus the burst output stream.
// "master" is the reader's view and "slave" is the environment's view.
interface fifo_burst_reader_if #(
  parameter int LOG2_FIFO_DEPTH = 3,
  parameter int FIFO_WIDTH      = 8
);
  logic                     fifo_ren;
  logic [FIFO_WIDTH-1:0]    fifo_rdata;
  logic                     fifo_rempty;
  logic [LOG2_FIFO_DEPTH:0] fifo_rlevel;
  logic                     m_valid;
  logic                     m_ready;
  logic [FIFO_WIDTH-1:0]    m_data;
  logic                     m_first;
  logic                     m_last;
  logic                     busy;

  modport master (
    output fifo_ren,
    input  fifo_rdata, fifo_rempty, fifo_rlevel,
    output m_valid, m_data, m_first, m_last, busy,
    input  m_ready
  );

  modport slave (
    input  fifo_ren,
    output fifo_rdata, fifo_rempty, fifo_rlevel,
    input  m_valid, m_data, m_first, m_last, busy,
    output m_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains fixed-size bursts from the read side of the LUT FIFO, or a short burst after an idle timeout.
// Presents each burst as a valid/ready stream with first/last markers, through a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int LOG2_FIFO_DEPTH = 3,
  parameter int FIFO_WIDTH      = 8,
  parameter int BURST_LEN       = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic                clk,
  input  logic                srstn,
  fifo_burst_reader_if.master bus
);
  localparam int CW = LOG2_FIFO_DEPTH + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] BLEN     = CW'(BURST_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic [CW-1:0]              len_q, len_d;
  logic [CW-1:0]              issued_q, issued_d;
  logic [CW-1:0]              widx_q, widx_d;
  logic [1:0]                 occ_q, occ_d;
  logic                       pend_q;
  logic                       wptr_q, rptr_q;
  logic [1:0][FIFO_WIDTH-1:0] buf_q;

  logic       ren, valid, pop, last_word;
  logic [2:0] credit;

  assign valid     = (occ_q != 2'd0);
  assign pop       = valid && bus.m_ready;
  assign last_word = (widx_q == len_q - CW'(1));
  // Buffer entries left after this cycle's write/pop. A new read is issued only if its word will find a free slot.
  assign credit    = 3'(occ_q) + 3'(pend_q) - 3'(pop);

  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    len_d    = len_q;
    issued_d = issued_q;
    widx_d   = widx_q;
    occ_d    = occ_q + 2'(pend_q) - 2'(pop);
    ren      = 1'b0;
    unique case (state_q)
      IDLE: begin
        issued_d = '0;
        if (!bus.fifo_rempty && TIMEOUT != 0) tmo_d = tmo_q + 1'b1;
        if (bus.fifo_rlevel >= BLEN) begin
          state_d = READ;
          len_d   = BLEN;
          tmo_d   = '0;
        end else if (TIMEOUT != 0 && tmo_q == TMO_LAST && !bus.fifo_rempty) begin
          state_d = READ;
          len_d   = bus.fifo_rlevel;
          tmo_d   = '0;
        end
      end
      READ: begin
        ren = !bus.fifo_rempty && (issued_q < len_q) && (credit < 3'd2);
        if (ren) begin
          issued_d = issued_q + 1'b1;
          if (issued_q + 1'b1 == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) widx_d = last_word ? '0 : widx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      len_q    <= '0;
      issued_q <= '0;
      widx_q   <= '0;
      occ_q    <= '0;
      pend_q   <= 1'b0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      widx_q   <= widx_d;
      occ_q    <= occ_d;
      pend_q   <= ren;
      // Read data is valid the cycle after an accepted read.
      if (pend_q) begin
        buf_q[wptr_q] <= bus.fifo_rdata;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end

  assign bus.fifo_ren = ren;
  assign bus.m_valid  = valid;
  assign bus.m_data   = buf_q[rptr_q];
  assign bus.m_first  = valid && (widx_q == '0);
  assign bus.m_last   = valid && last_word;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed and randomized bench for fifo_burst_reader. It models the upstream FIFO as a queue.
// Expected bursts come from the chunking rule: full bursts while enough words are queued, then one short burst with the rest.
module tb_fifo_burst_reader;
  localparam int LD  = 3;
  localparam int W   = 8;
  localparam int BL  = 4;
  localparam int TMO = 16;
  localparam int LW  = LD + 1;

  typedef struct packed { logic [W-1:0] d; logic f; logic l; } beat_t;

  logic clk   = 1'b0;
  logic srstn = 1'b0;
  always #5 clk = ~clk;

  fifo_burst_reader_if #(.LOG2_FIFO_DEPTH(LD), .FIFO_WIDTH(W)) bus ();

  fifo_burst_reader #(
    .LOG2_FIFO_DEPTH(LD), .FIFO_WIDTH(W), .BURST_LEN(BL), .TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .srstn(srstn),
    .bus  (bus)
  );

  logic [W-1:0] fq[$];
  beat_t        exp_q[$];
  int           vectors = 0, miscompares = 0;
  int           rd_cnt = 0, pop_cnt = 0;
  int           mode = 0;
  bit           tput_en = 1'b0;
  bit           prv_stall = 1'b0, prv_pop = 1'b0;
  beat_t        prv_beat;
  bit           acc;
  logic [W-1:0] rd_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each group is pushed at once. Full bursts are taken while BL or more words remain, and the rest goes out as one timeout burst.
  task automatic push_group(input int n, input logic [W-1:0] base, input bit rnd);
    logic [W-1:0] w;
    int left, len, k;
    left = n;
    k    = 0;
    while (left > 0) begin
      len = (left >= BL) ? BL : left;
      for (int j = 0; j < len; j++) begin
        w = rnd ? W'($urandom) : base + W'(k);
        fq.push_back(w);
        exp_q.push_back('{d: w, f: (j == 0), l: (j == len - 1)});
        k++;
      end
      left -= len;
    end
  endtask

  // Entered and left at a negedge. Checks outputs, services the FIFO model, and then advances one clock.
  task automatic tick();
    beat_t cur, e;
    cur = '{d: bus.m_data, f: bus.m_first, l: bus.m_last};
    if (prv_stall) begin
      chk("stall_valid", 32'(bus.m_valid), 1);
      chk("stall_hold", 32'(cur), 32'(prv_beat));
    end
    if (tput_en && prv_pop && !prv_beat.l) chk("throughput", 32'(bus.m_valid), 1);
    if (bus.fifo_ren === 1'b1) chk("ren_when_empty", 32'(bus.fifo_rempty), 0);
    acc = (bus.fifo_ren === 1'b1) && !bus.fifo_rempty && (fq.size() > 0);
    if (acc) begin
      rd_hold = fq.pop_front();
      rd_cnt++;
    end
    if (bus.m_valid === 1'b1 && bus.m_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL extra_word: observed %0h expected no word", cur);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 32'(cur), 32'(e));
      end
    end
    if (acc || (bus.m_valid === 1'b1 && bus.m_ready))
      chk("credit", 32'((rd_cnt - pop_cnt) <= 2), 1);
    prv_stall = (bus.m_valid === 1'b1) && !bus.m_ready;
    prv_pop   = (bus.m_valid === 1'b1) && bus.m_ready;
    prv_beat  = cur;
    @(posedge clk);
    #1;
    if (acc) bus.fifo_rdata = rd_hold;
    bus.fifo_rlevel = LW'(fq.size());
    bus.fifo_rempty = (fq.size() == 0);
    case (mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = ~bus.m_ready;
      default: bus.m_ready = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 0);
    chk("idle_after", 32'(bus.busy), 0);
    repeat (3) tick();
  endtask

  task automatic measure_latency(input string tag, input int exp_lat);
    int lat;
    lat = -1;
    tick();
    for (int k = 0; k < 30; k++) begin
      if (lat < 0 && bus.m_valid === 1'b1) lat = k;
      tick();
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int base, n;
    bus.fifo_rdata  = '0;
    bus.fifo_rempty = 1'b1;
    bus.fifo_rlevel = '0;
    bus.m_ready     = 1'b0;
    srstn           = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_ren",   32'(bus.fifo_ren), 0);
    chk("rst_valid", 32'(bus.m_valid),  0);
    chk("rst_first", 32'(bus.m_first),  0);
    chk("rst_last",  32'(bus.m_last),   0);
    chk("rst_busy",  32'(bus.busy),     0);
    chk("rst_data",  32'(bus.m_data),   0);
    srstn = 1'b1;
    mode  = 0;
    repeat (3) tick();

    // Two full bursts with one word per cycle. The first word appears 3 cycles after the decision cycle.
    tput_en = 1'b1;
    push_group(8, 8'h10, 1'b0);
    measure_latency("burst_latency", 3);
    wait_drain(100);
    tput_en = 1'b0;

    // Short bursts after 16 non-empty idle cycles. The first word appears 15 + 3 cycles after the level rises.
    push_group(2, 8'hA0, 1'b0);
    measure_latency("timeout_latency_2", 18);
    wait_drain(100);
    push_group(1, 8'h55, 1'b0);
    measure_latency("timeout_latency_1", 18);
    wait_drain(100);

    // Backpressure that alternates every cycle.
    mode = 1;
    push_group(4, 8'h00, 1'b0);
    wait_drain(100);
    mode = 0;

    // The 4th word arrives after the 3-word timeout burst is committed, so it forms a burst of its own.
    push_group(3, 8'h30, 1'b0);
    repeat (20) tick();
    push_group(1, 8'h33, 1'b0);
    wait_drain(100);

    // Reset is pulsed after the second word of a full burst.
    push_group(4, 8'h60, 1'b0);
    base = pop_cnt;
    n    = 0;
    while (pop_cnt - base < 2 && n < 30) begin
      tick();
      n++;
    end
    chk("pre_reset_pops", 32'(pop_cnt - base), 2);
    srstn = 1'b0;
    tick();
    srstn = 1'b1;
    chk("mid_rst_ren",   32'(bus.fifo_ren), 0);
    chk("mid_rst_valid", 32'(bus.m_valid),  0);
    chk("mid_rst_first", 32'(bus.m_first),  0);
    chk("mid_rst_last",  32'(bus.m_last),   0);
    chk("mid_rst_busy",  32'(bus.busy),     0);
    chk("mid_rst_data",  32'(bus.m_data),   0);
    fq.delete();
    exp_q.delete();
    bus.fifo_rempty = 1'b1;
    bus.fifo_rlevel = '0;
    rd_cnt    = 0;
    pop_cnt   = 0;
    prv_stall = 1'b0;
    prv_pop   = 1'b0;
    repeat (20) begin
      tick();
      chk("no_ren_after_rst", 32'(bus.fifo_ren), 0);
    end
    push_group(4, 8'h70, 1'b0);
    wait_drain(100);

    // Random group sizes and data, with random backpressure.
    mode = 2;
    for (int r = 0; r < 12; r++) begin
      push_group(int'($urandom_range(1, 8)), 8'h00, 1'b1);
      wait_drain(400);
    end
    mode = 0;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
